// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
// The UART_RX_PARITY_EN build uses the PARITY state; otherwise it is unused.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Integer truncation matches the uart_tx divisor exactly.
   function automatic int clks_per_bit(input int f, input int baud);
      return f / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line plus falling-edge detect.
// All flops reset to 1, the idle line level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic start_edge
);

   logic meta;
   logic rx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         rx_s <= 1'b1;
         rx_q <= 1'b1;
      end else begin
         meta <= rx;
         rx_s <= meta;
         rx_q <= rx_s;
      end
   end

   assign start_edge = rx_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing error detect.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects sense).
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD = 115200,
   parameter int F    = 50000000
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy,
   output logic       parity_err
);

   localparam int CLKS_PER_BIT = clks_per_bit(F, BAUD);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

   logic          rx_s;
   logic          start_edge;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_n;
   logic          valid_n;
   logic          ferr_n;

`ifdef UART_RX_PARITY_EN
   logic          par_bad, par_bad_n;
   logic          perr_n;
`endif

   uart_rx_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_s       (rx_s),
      .start_edge (start_edge)
   );

   always_comb begin
      state_n = state;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      perr_n    = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (start_edge) state_n = START;
         end
         START: begin
            if (cnt == CNT_HALF) begin
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               shreg_n = {rx_s, shreg[7:1]};
               idx_n   = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CNT_LAST) begin
               par_bad_n = rx_s ^ (^shreg) ^ PARITY_ODD;
               state_n   = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at mid-stop so a back-to-back start edge is caught.
            if (cnt == CNT_LAST) begin
               state_n = IDLE;
               if (!rx_s) begin
                  ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad) begin
                  perr_n = 1'b1;
`endif
               end else begin
                  valid_n = 1'b1;
                  data_n  = shreg;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_n != state || state == IDLE || cnt == CNT_LAST)
         cnt_n = '0;
      else
         cnt_n = cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= ferr_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= par_bad_n;
         parity_err <= perr_n;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at F=16, BAUD=1 (16 clocks per bit).
module tb_uart_rx;

   localparam int C = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2 + 8 + 10 * C + 1;
`else
   localparam int LAT = 2 + 8 + 9 * C + 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;
   logic       parity_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int vcnt = 0;
   int fcnt = 0;
   int pcnt = 0;
   int viol = 0;
   int last_vcyc = 0;
   int fall_cyc = 0;
   int v0, f0, p0;
   bit prev_any = 1'b0;
   logic [7:0] vlog[$];

   always #5 clk = ~clk;

   uart_rx #(.BAUD(1), .F(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .valid      (valid),
      .frame_err  (frame_err),
      .busy       (busy),
      .parity_err (parity_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         vcnt++;
         vlog.push_back(data);
         last_vcyc = cyc;
      end
      if (frame_err === 1'b1) fcnt++;
      if (parity_err === 1'b1) pcnt++;
      if ((int'(valid) + int'(frame_err) + int'(parity_err)) > 1) viol++;
      if (prev_any && (valid || frame_err || parity_err)) viol++;
      prev_any = valid || frame_err || parity_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic b);
      rx = b;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input logic par_flip);
      @(negedge clk);
      fall_cyc = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
      bit_time((^b) ^ par_flip);
`else
      if (par_flip) $display("note: parity flip ignored");
`endif
      rx = stop;
      repeat (C - 1) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data", data, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_perr", parity_err, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // single frame 0x55 with latency
      v0 = vcnt;
      f0 = fcnt;
      send_frame(8'h55, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("f55_count", vcnt - v0, 1);
      chk("f55_data", data, 8'h55);
      chk("f55_lat", last_vcyc - fall_cyc, LAT);
      chk("f55_ferr", fcnt - f0, 0);

      // back-to-back 0..7
      v0 = vcnt;
      for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b0);
      repeat (2 * C) @(negedge clk);
      chk("b2b_count", vcnt - v0, 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("b2b_data%0d", i), vlog[v0 + i], i);

      // 5-clk glitch
      v0 = vcnt;
      f0 = fcnt;
      @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      chk("glitch_busy_hi", busy, 1'b1);
      repeat (7) @(negedge clk);
      chk("glitch_busy_lo", busy, 1'b0);
      repeat (2 * C) @(negedge clk);
      chk("glitch_valid", vcnt - v0, 0);
      chk("glitch_ferr", fcnt - f0, 0);

      // framing error then line held low
      v0 = vcnt;
      f0 = fcnt;
      send_frame(8'hA3, 1'b0, 1'b0);
      repeat (40 * C) @(negedge clk);
      chk("brk_ferr", fcnt - f0, 1);
      chk("brk_valid", vcnt - v0, 0);
      chk("brk_data", data, 8'h07);
      chk("brk_busy", busy, 1'b0);
      rx = 1'b1;
      repeat (2 * C) @(negedge clk);
      send_frame(8'h5A, 1'b1, 1'b0);
      repeat (C) @(negedge clk);
      chk("brk_rec_count", vcnt - v0, 1);
      chk("brk_rec_data", data, 8'h5A);

      // reset mid-frame
      v0 = vcnt;
      f0 = fcnt;
      @(negedge clk);
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b1);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rmid_busy", busy, 1'b0);
      chk("rmid_data", data, 8'h00);
      rst = 1'b0;
      repeat (2 * C) @(negedge clk);
      chk("rmid_nopulse", vcnt + fcnt - v0 - f0, 0);
      send_frame(8'h3C, 1'b1, 1'b0);
      repeat (C) @(negedge clk);
      chk("rmid_count", vcnt - v0, 1);
      chk("rmid_data2", data, 8'h3C);

`ifdef UART_RX_PARITY_EN
      v0 = vcnt;
      p0 = pcnt;
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (C) @(negedge clk);
      chk("par_bad_perr", pcnt - p0, 1);
      chk("par_bad_valid", vcnt - v0, 0);
      chk("par_bad_data", data, 8'h3C);
      send_frame(8'h07, 1'b1, 1'b0);
      repeat (C) @(negedge clk);
      chk("par_ok_valid", vcnt - v0, 1);
      chk("par_ok_data", data, 8'h07);
      chk("par_ok_perr", pcnt - p0, 1);
`else
      p0 = pcnt;
      chk("perr_tied", pcnt - p0 + int'(parity_err), 0);
`endif

      chk("exclusive", viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
